// File: rtl/hvsync_pkg.sv
// Shared timing constants and position type for the VGA sync generator.
// Defaults describe standard 640x480 @ 60 Hz timing.
package hvsync_pkg;

    localparam int POS_W = 10;

    localparam int H_DISPLAY_DEF = 640;
    localparam int H_FRONT_DEF   = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BACK_DEF    = 48;

    localparam int V_DISPLAY_DEF = 480;
    localparam int V_BOTTOM_DEF  = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_TOP_DEF     = 33;

    typedef logic [POS_W-1:0] pos_t;

    // Inclusive window test used for the sync pulse decode.
    function automatic logic in_window(pos_t pos, pos_t lo, pos_t hi);
        return (pos >= lo) && (pos <= hi);
    endfunction

endpackage

// File: rtl/hvsync_axis_counter.sv
// One axis of the raster scan: a wrap counter with a registered sync-window decode.
// Used once for the horizontal axis and once for the vertical axis.
module hvsync_axis_counter
    import hvsync_pkg::*;
#(
    parameter int MAX        = 799,
    parameter int SYNC_START = 656,
    parameter int SYNC_END   = 751,
    parameter int DISPLAY    = 640,
    parameter bit SYNC_POL   = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    output logic [POS_W-1:0] pos_o,
    output logic             wrap_o,
    output logic             sync_o,
    output logic             active_o
);

    localparam pos_t MaxPos    = pos_t'(MAX);
    localparam pos_t SyncStart = pos_t'(SYNC_START);
    localparam pos_t SyncEnd   = pos_t'(SYNC_END);
    localparam pos_t DispPos   = pos_t'(DISPLAY);

    pos_t pos_q, pos_d;
    logic sync_q, sync_d;

    // Sync is decoded from the next position so the registered pulse lines up with pos_q.
    always_comb begin
        pos_d = pos_q;
        if (en_i) begin
            pos_d = (pos_q == MaxPos) ? '0 : pos_q + pos_t'(1);
        end
        sync_d = in_window(pos_d, SyncStart, SyncEnd) ? SYNC_POL : ~SYNC_POL;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pos_q  <= '0;
            sync_q <= ~SYNC_POL;
        end else begin
            pos_q  <= pos_d;
            sync_q <= sync_d;
        end
    end

    assign pos_o    = pos_q;
    assign wrap_o   = en_i && (pos_q == MaxPos);
    assign sync_o   = sync_q;
    assign active_o = (pos_q < DispPos);

endmodule

// File: rtl/hvsync_generator.sv
// VGA horizontal/vertical sync and raster position generator.
// Define HVSYNC_PIXEL_CE_EN to add a pix_ce input that qualifies counting edges.
module hvsync_generator
    import hvsync_pkg::*;
#(
    parameter int H_DISPLAY = H_DISPLAY_DEF,
    parameter int H_FRONT   = H_FRONT_DEF,
    parameter int H_SYNC    = H_SYNC_DEF,
    parameter int H_BACK    = H_BACK_DEF,
    parameter int V_DISPLAY = V_DISPLAY_DEF,
    parameter int V_BOTTOM  = V_BOTTOM_DEF,
    parameter int V_SYNC    = V_SYNC_DEF,
    parameter int V_TOP     = V_TOP_DEF,
    parameter bit SYNC_POL  = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    output logic             hsync,
    output logic             vsync,
    output logic             display_on,
    output logic [POS_W-1:0] hpos,
    output logic [POS_W-1:0] vpos
`ifdef HVSYNC_PIXEL_CE_EN
    ,
    input  logic             pix_ce
`endif
);

    localparam int H_MAX = H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1;
    localparam int V_MAX = V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP - 1;

    logic ce;
    logic hWrap;
    logic vWrap;
    logic hActive;
    logic vActive;

`ifdef HVSYNC_PIXEL_CE_EN
    assign ce = pix_ce;
`else
    assign ce = 1'b1;
`endif

    hvsync_axis_counter #(
        .MAX        (H_MAX),
        .SYNC_START (H_DISPLAY + H_FRONT),
        .SYNC_END   (H_DISPLAY + H_FRONT + H_SYNC - 1),
        .DISPLAY    (H_DISPLAY),
        .SYNC_POL   (SYNC_POL)
    ) u_h_axis (
        .clk      (clk),
        .reset    (reset),
        .en_i     (ce),
        .pos_o    (hpos),
        .wrap_o   (hWrap),
        .sync_o   (hsync),
        .active_o (hActive)
    );

    // The vertical axis only steps on the edge where the line wraps.
    hvsync_axis_counter #(
        .MAX        (V_MAX),
        .SYNC_START (V_DISPLAY + V_BOTTOM),
        .SYNC_END   (V_DISPLAY + V_BOTTOM + V_SYNC - 1),
        .DISPLAY    (V_DISPLAY),
        .SYNC_POL   (SYNC_POL)
    ) u_v_axis (
        .clk      (clk),
        .reset    (reset),
        .en_i     (hWrap),
        .pos_o    (vpos),
        .wrap_o   (vWrap),
        .sync_o   (vsync),
        .active_o (vActive)
    );

    assign display_on = hActive && vActive;

    logic unusedVWrap;
    assign unusedVWrap = vWrap;

endmodule

// File: tb/tb_hvsync_generator.sv
// Directed bench for hvsync_generator: default horizontal timing, shortened vertical timing
// (8 visible + 2 + 2 + 2 lines, V_MAX=13, vsync lines 10..11, frame 11200 clocks).
module tb_hvsync_generator;

    logic       clk;
    logic       reset;
    logic       hsync;
    logic       vsync;
    logic       display_on;
    logic [9:0] hpos;
    logic [9:0] vpos;
    logic       pixCe;

    int errors = 0;
    int checks = 0;

    hvsync_generator #(
        .V_DISPLAY (8),
        .V_BOTTOM  (2),
        .V_SYNC    (2),
        .V_TOP     (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .hsync      (hsync),
        .vsync      (vsync),
        .display_on (display_on),
        .hpos       (hpos),
        .vpos       (vpos)
`ifdef HVSYNC_PIXEL_CE_EN
        ,
        .pix_ce     (pixCe)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        pixCe = 1'b1;
        repeat (3) tick();
        checks++; if (hpos !== 10'd0) begin errors++; $display("[TB] FAIL reset_hpos: got %0d expected 0", hpos); end
        checks++; if (vpos !== 10'd0) begin errors++; $display("[TB] FAIL reset_vpos: got %0d expected 0", vpos); end
        checks++; if (hsync !== 1'b1) begin errors++; $display("[TB] FAIL reset_hsync: got %b expected 1", hsync); end
        checks++; if (vsync !== 1'b1) begin errors++; $display("[TB] FAIL reset_vsync: got %b expected 1", vsync); end
        checks++; if (display_on !== 1'b1) begin errors++; $display("[TB] FAIL reset_display_on: got %b expected 1", display_on); end
        @(negedge clk);
        reset = 1'b1;
        tick();
        checks++; if (hpos !== 10'd1 || vpos !== 10'd0) begin errors++; $display("[TB] FAIL reset_first_count: got %0d,%0d expected 1,0", hpos, vpos); end
    endtask

    task automatic test_line_timing();
        int lowCnt = 0;
        int firstLow = -1;
        int lastLow = -1;
        int posErr = 0;
        for (int h = 2; h <= 799; h++) begin
            tick();
            if (hpos !== 10'(h) || vpos !== 10'd0) posErr++;
            if (hsync === 1'b0) begin
                lowCnt++;
                if (firstLow < 0) firstLow = int'(hpos);
                lastLow = int'(hpos);
            end
            if (h == 639) begin
                checks++; if (display_on !== 1'b1) begin errors++; $display("[TB] FAIL line_disp_639: got %b expected 1", display_on); end
            end
            if (h == 640) begin
                checks++; if (hpos !== 10'd640) begin errors++; $display("[TB] FAIL line_hpos_640: got %0d expected 640", hpos); end
                checks++; if (display_on !== 1'b0) begin errors++; $display("[TB] FAIL line_disp_640: got %b expected 0", display_on); end
            end
            if (h == 752) begin
                checks++; if (hsync !== 1'b1) begin errors++; $display("[TB] FAIL line_hsync_752: got %b expected 1", hsync); end
            end
        end
        checks++; if (posErr != 0) begin errors++; $display("[TB] FAIL line_hpos_seq: got %0d bad cycles expected 0", posErr); end
        checks++; if (lowCnt != 96) begin errors++; $display("[TB] FAIL hsync_width: got %0d expected 96", lowCnt); end
        checks++; if (firstLow != 656) begin errors++; $display("[TB] FAIL hsync_start: got %0d expected 656", firstLow); end
        checks++; if (lastLow != 751) begin errors++; $display("[TB] FAIL hsync_end: got %0d expected 751", lastLow); end
    endtask

    task automatic test_line_wrap();
        checks++; if (hpos !== 10'd799 || vpos !== 10'd0) begin errors++; $display("[TB] FAIL wrap_pre: got %0d,%0d expected 799,0", hpos, vpos); end
        tick();
        checks++; if (hpos !== 10'd0 || vpos !== 10'd1) begin errors++; $display("[TB] FAIL wrap_line: got %0d,%0d expected 0,1", hpos, vpos); end
        repeat (13 * 800 - 1) tick();
        checks++; if (hpos !== 10'd799 || vpos !== 10'd13) begin errors++; $display("[TB] FAIL wrap_last_pixel: got %0d,%0d expected 799,13", hpos, vpos); end
        checks++; if (display_on !== 1'b0) begin errors++; $display("[TB] FAIL wrap_last_disp: got %b expected 0", display_on); end
        tick();
        checks++; if (hpos !== 10'd0 || vpos !== 10'd0) begin errors++; $display("[TB] FAIL wrap_frame: got %0d,%0d expected 0,0", hpos, vpos); end
        checks++; if (display_on !== 1'b1) begin errors++; $display("[TB] FAIL wrap_frame_disp: got %b expected 1", display_on); end
    endtask

    task automatic test_frame_timing();
        int waitCnt = 0;
        int lowCnt = 0;
        int period = 0;
        while (vsync !== 1'b0 && waitCnt < 20000) begin
            tick();
            waitCnt++;
        end
        checks++; if (vsync !== 1'b0) begin errors++; $display("[TB] FAIL vsync_start_timeout: got %b expected 0", vsync); end
        checks++; if (hpos !== 10'd0 || vpos !== 10'd10) begin errors++; $display("[TB] FAIL vsync_start_pos: got %0d,%0d expected 0,10", hpos, vpos); end
        while (vsync === 1'b0 && lowCnt < 20000) begin
            tick();
            lowCnt++;
            period++;
        end
        checks++; if (lowCnt != 1600) begin errors++; $display("[TB] FAIL vsync_width: got %0d expected 1600", lowCnt); end
        while (vsync !== 1'b0 && period < 30000) begin
            tick();
            period++;
        end
        checks++; if (period != 11200) begin errors++; $display("[TB] FAIL frame_period: got %0d expected 11200", period); end
    endtask

    task automatic test_mid_reset();
        int waitCnt = 0;
        while (!(hpos === 10'd300 && vpos === 10'd5) && waitCnt < 12000) begin
            tick();
            waitCnt++;
        end
        checks++; if (hpos !== 10'd300 || vpos !== 10'd5) begin errors++; $display("[TB] FAIL midreset_reach: got %0d,%0d expected 300,5", hpos, vpos); end
        #2;
        reset = 1'b0;
        #1;
        checks++; if (hpos !== 10'd0 || vpos !== 10'd0) begin errors++; $display("[TB] FAIL midreset_pos: got %0d,%0d expected 0,0", hpos, vpos); end
        checks++; if (hsync !== 1'b1 || vsync !== 1'b1) begin errors++; $display("[TB] FAIL midreset_sync: got %b%b expected 11", hsync, vsync); end
        checks++; if (display_on !== 1'b1) begin errors++; $display("[TB] FAIL midreset_disp: got %b expected 1", display_on); end
        repeat (2) tick();
        checks++; if (hpos !== 10'd0 || vpos !== 10'd0) begin errors++; $display("[TB] FAIL midreset_hold: got %0d,%0d expected 0,0", hpos, vpos); end
        @(negedge clk);
        reset = 1'b1;
        tick();
        checks++; if (hpos !== 10'd1 || vpos !== 10'd0) begin errors++; $display("[TB] FAIL midreset_restart: got %0d,%0d expected 1,0", hpos, vpos); end
    endtask

`ifdef HVSYNC_PIXEL_CE_EN
    task automatic test_pixel_ce();
        int n = 0;
        int lowCnt = 0;
        int startH;
        reset = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        reset = 1'b1;
        startH = int'(hpos);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            pixCe = (n % 4 == 0);
            tick();
            n++;
        end
        checks++; if (int'(hpos) != startH + 2) begin errors++; $display("[TB] FAIL ce_advance: got %0d expected %0d", hpos, startH + 2); end
        while (hsync !== 1'b0 && n < 4000) begin
            @(negedge clk);
            pixCe = (n % 4 == 0);
            tick();
            n++;
        end
        while (hsync === 1'b0 && lowCnt < 1000) begin
            @(negedge clk);
            pixCe = (n % 4 == 0);
            tick();
            n++;
            lowCnt++;
        end
        checks++; if (lowCnt != 384) begin errors++; $display("[TB] FAIL ce_hsync_width: got %0d expected 384", lowCnt); end
        @(negedge clk);
        pixCe = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_line_timing();
        test_line_wrap();
        test_frame_timing();
        test_mid_reset();
`ifdef HVSYNC_PIXEL_CE_EN
        test_pixel_ce();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
